// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, computes single-cycle ops directly and
// shifts one bit per cycle. Optional shift-add multiplier enabled by ALU_EXEC_MUL_EN.
module alu_exec_unit #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       operation,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal,
    output logic             stall
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                           OP_XOR = 4'b0011, OP_BNE = 4'b0101, OP_SUB = 4'b0110,
                           OP_SLL = 4'b0111, OP_SRL = 4'b1000, OP_SRA = 4'b1001,
                           OP_BLT = 4'b1010, OP_MUL = 4'b1100, OP_ILL = 4'b1111;

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    function automatic logic [3:0] decode(input logic [1:0] aop, input logic [3:0] f);
        logic [3:0] op;
        op = OP_ILL;
        case (aop)
            2'b00: op = (f == 4'b0001) ? OP_SLL : OP_ADD;
            2'b01: case (f)
                4'b0000: op = OP_SUB;   // BEQ shares the subtract code
                4'b0001: op = OP_BNE;
                4'b0100: op = OP_BLT;
                default: op = OP_ILL;
            endcase
            2'b10: case (f)
                4'b0000: op = OP_ADD;
                4'b1000: op = OP_SUB;
                4'b0111: op = OP_AND;
                4'b0110: op = OP_OR;
                4'b0100: op = OP_XOR;
                4'b0001: op = OP_SLL;
                4'b0101: op = OP_SRL;
                4'b1101: op = OP_SRA;
`ifdef ALU_EXEC_MUL_EN
                4'b1100: op = OP_MUL;
`endif
                default: op = OP_ILL;
            endcase
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  return v << 1;
            OP_SRL:  return v >> 1;
            OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_next;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, branch_q, branch_d, illegal_q, illegal_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_br, accept;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SHAMT_W-1:0] shamt;
`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
`endif

    assign operation = decode(alu_op, funct);
    assign shamt     = b[SHAMT_W-1:0];
    assign a_s       = a;
    assign b_s       = b;
    assign accept    = (state_q == S_IDLE) && in_valid && !flush;
    assign stall     = (state_q != S_IDLE) ||
                       ((state_q == S_IDLE) && in_valid && !flush && (operation == OP_MUL));

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (operation)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD: alu_res = a + b;
            OP_SUB, OP_BNE: alu_res = a - b;
            OP_SLL, OP_SRL, OP_SRA: alu_res = (shamt == '0) ? a : shift1(operation, a);
            OP_BLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: alu_res = '0;
        endcase
        if (alu_op == 2'b01) begin
            case (operation)
                OP_SUB:  alu_br = (a == b);
                OP_BNE:  alu_br = (a != b);
                OP_BLT:  alu_br = (a_s < b_s);
                default: alu_br = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_next    = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        branch_d    = branch_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                op_d = operation;
                if (is_shift(operation) && (shamt > SHAMT_W'(1))) begin
                    acc_d   = shift1(operation, a);
                    cnt_d   = shamt - SHAMT_W'(1);
                    state_d = S_SHIFT;
`ifdef ALU_EXEC_MUL_EN
                end else if (operation == OP_MUL) begin
                    acc_d    = b[0] ? a : '0;
                    mcand_d  = a << 1;
                    mplier_d = b >> 1;
                    cnt_d    = SHAMT_W'(WIDTH - 1);
                    state_d  = S_MUL;
`endif
                end else begin
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    branch_d    = alu_br;
                    illegal_d   = (operation == OP_ILL);
                    out_valid_d = 1'b1;
                end
            end
            S_SHIFT: if (flush) begin
                state_d = S_IDLE;
            end else begin
                acc_next = shift1(op_q, acc_q);
                acc_d    = acc_next;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    branch_d    = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            S_MUL: if (flush) begin
                state_d = S_IDLE;
            end else begin
                acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    branch_d    = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Working registers are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        cnt_q    <= cnt_d;
        acc_q    <= acc_d;
`ifdef ALU_EXEC_MUL_EN
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
`endif
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_exec_unit;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, in_valid, flush;
    logic [1:0]   alu_op;
    logic [3:0]   funct;
    logic [W-1:0] a, b;
    logic [3:0]   operation;
    logic         out_valid, zero, branch_taken, illegal, stall;
    logic [W-1:0] result;

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .operation(operation), .out_valid(out_valid), .result(result),
        .zero(zero), .branch_taken(branch_taken), .illegal(illegal), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         br;
        logic         il;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got result %0h expected no output", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.r);
                chk("zero", W'(zero), W'(e.z));
                chk("branch_taken", W'(branch_taken), W'(e.br));
                chk("illegal", W'(illegal), W'(e.il));
            end
        end
    end

    task automatic push(input logic [W-1:0] r, input logic z, input logic br, input logic il);
        exp_t e;
        e.r = r; e.z = z; e.br = br; e.il = il;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] aop, input logic [3:0] f,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        alu_op = aop; funct = f; a = av; b = bv; in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", W'(q.size()), '0);
    endtask

    task automatic dchk(input logic [1:0] aop, input logic [3:0] f, input logic [3:0] expop);
        alu_op = aop; funct = f;
        #1;
        chk("decode", W'(operation), W'(expop));
    endtask

    // Count negedges after the accept edge until out_valid, plus stall cycles seen meanwhile.
    task automatic measure(output int n, output int st, input int bound);
        n = 0; st = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (stall) st++;
        end
    endtask

    initial begin
        int n, st;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        alu_op = '0; funct = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), '0);
        chk("rst_branch", W'(branch_taken), '0);
        chk("rst_illegal", W'(illegal), '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_stall", W'(stall), '0);
        reset = 1'b0;

        dchk(2'b00, 4'b0001, 4'b0111);
        dchk(2'b00, 4'b0101, 4'b0010);
        dchk(2'b01, 4'b0000, 4'b0110);
        dchk(2'b01, 4'b0001, 4'b0101);
        dchk(2'b01, 4'b0100, 4'b1010);
        dchk(2'b01, 4'b0010, 4'b1111);
        dchk(2'b10, 4'b0000, 4'b0010);
        dchk(2'b10, 4'b1000, 4'b0110);
        dchk(2'b10, 4'b0111, 4'b0000);
        dchk(2'b10, 4'b0110, 4'b0001);
        dchk(2'b10, 4'b0100, 4'b0011);
        dchk(2'b10, 4'b0101, 4'b1000);
        dchk(2'b10, 4'b1101, 4'b1001);
`ifdef ALU_EXEC_MUL_EN
        dchk(2'b10, 4'b1100, 4'b1100);
`else
        dchk(2'b10, 4'b1100, 4'b1111);
`endif
        dchk(2'b10, 4'b1010, 4'b1111);
        dchk(2'b11, 4'b0000, 4'b1111);

        @(negedge clk);
        // Back-to-back SUB then AND, then branches and misc single-cycle ops
        drive(2'b10, 4'b1000, 64'd5, 64'd5);     push(64'd0, 1, 0, 0);    step();
        drive(2'b10, 4'b0111, 64'hF0, 64'h3C);   push(64'h30, 0, 0, 0);   step();
        drive(2'b01, 4'b0100, '1, 64'd1);        push(64'd1, 0, 1, 0);    step();
        drive(2'b01, 4'b0001, 64'd7, 64'd7);     push(64'd0, 1, 0, 0);    step();
        drive(2'b01, 4'b0000, 64'd7, 64'd7);     push(64'd0, 1, 1, 0);    step();
        drive(2'b01, 4'b0000, 64'd9, 64'd7);     push(64'd2, 0, 0, 0);    step();
        drive(2'b00, 4'b0110, 64'd2, 64'd3);     push(64'd5, 0, 0, 0);    step();
        drive(2'b10, 4'b0110, 64'hA0, 64'h0A);   push(64'hAA, 0, 0, 0);   step();
        drive(2'b10, 4'b0100, 64'hFF, 64'h0F);   push(64'hF0, 0, 0, 0);   step();
        drive(2'b10, 4'b0000, '1, 64'd1);        push(64'd0, 1, 0, 0);    step();
        drive(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd0);
        push(64'h8000_0000_0000_0000, 0, 0, 0); step();
        drive(2'b10, 4'b0101, 64'h10, 64'd1);    push(64'h8, 0, 0, 0);    step();
        drain();

        // SRA by 4: stall stays low in the accept cycle, then 3 stalled cycles
        @(negedge clk);
        drive(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4);
        push(64'hF800_0000_0000_0000, 0, 0, 0);
        #1;
        chk("sra_accept_stall", W'(stall), '0);
        step();
        measure(n, st, 20);
        chk("sra_latency", W'(n), W'(4));
        chk("sra_stall_cycles", W'(st), W'(3));
        drain();

        // SLL by 3 through the iterative path, with b's upper bits ignored
        @(negedge clk);
        drive(2'b10, 4'b0001, 64'd1, 64'hFF00_0000_0000_0003); push(64'd8, 0, 0, 0); step();
        drain();

        // SLL by 20 flushed during its fifth cycle; outputs must hold
        @(negedge clk);
        drive(2'b10, 4'b0001, 64'd1, 64'd20);
        step();
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", W'(stall), '0);
        chk("flush_no_valid", W'(out_valid), '0);
        chk("flush_hold_result", result, 64'd8);
        drive(2'b10, 4'b0000, 64'd2, 64'd3);     push(64'd5, 0, 0, 0);    step();
        drain();

        // flush together with in_valid in IDLE: nothing accepted
        @(negedge clk);
        drive(2'b10, 4'b0000, 64'd4, 64'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_reject", W'(out_valid), '0);

        // MUL 7x6
        @(negedge clk);
        drive(2'b10, 4'b1100, 64'd7, 64'd6);
`ifdef ALU_EXEC_MUL_EN
        push(64'd42, 0, 0, 0);
        #1;
        chk("mul_accept_stall", W'(stall), '1);
        step();
        measure(n, st, 100);
        chk("mul_latency", W'(n), W'(64));
        chk("mul_stall_cycles", W'(st), W'(63));
`else
        push(64'd0, 1, 0, 1);
        #1;
        chk("mul_accept_stall", W'(stall), '0);
        step();
        measure(n, st, 20);
        chk("mul_latency", W'(n), W'(1));
`endif
        drain();

        // Illegal encodings leave illegal=1 and zero=1 ahead of the reset test
        @(negedge clk);
        drive(2'b01, 4'b0010, 64'd3, 64'd1);     push(64'd0, 1, 0, 1);    step();
        drive(2'b11, 4'b0000, 64'd3, 64'd1);     push(64'd0, 1, 0, 1);    step();
        drain();

        // Reset mid-SHIFT
        @(negedge clk);
        drive(2'b10, 4'b0001, 64'd1, 64'd40);
        step();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_result", result, '0);
        chk("midrst_zero", W'(zero), '0);
        chk("midrst_illegal", W'(illegal), '0);
        chk("midrst_branch", W'(branch_taken), '0);
        chk("midrst_out_valid", W'(out_valid), '0);
        chk("midrst_stall", W'(stall), '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("final_queue_empty", W'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the 5-stage pipeline: decodes `alu_op`/`funct` into an operation, computes it on WIDTH-bit operands, and registers result, zero flag and branch decision for the EX/MEM boundary. Shifts run iteratively, one bit per cycle, and the unit raises `stall` to the hazard unit while busy. It absorbs the combinational ALU-control decode and extends it with width parametrisation, new operations, multi-cycle ops and a flush path.

## Interface
- `WIDTH`, 64: operand/result width (power of two, ≥8).
- `SHAMT_W`, 6: shift-amount width, equals log2(WIDTH).

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operation presented this cycle.
- `flush` input 1: synchronous abort of in-flight/presented op.
- `alu_op` input 2: main-decoder ALUOp.
- `funct` input 4: {instr[30], funct3}.
- `a` input WIDTH: operand A (rs1).
- `b` input WIDTH: operand B (rs2/imm); `b[SHAMT_W-1:0]` is the shift amount.
- `operation` output 4: combinational decode of current `alu_op`/`funct`.
- `out_valid` output 1: one-cycle pulse, result fields valid.
- `result` output WIDTH: registered result.
- `zero` output 1: registered (`result == 0`).
- `branch_taken` output 1: registered branch decision.
- `illegal` output 1: registered, completed op was an undefined encoding.
- `stall` output 1: combinational, hold upstream stages.

## Operation
- Decode (`operation` codes):
  - `alu_op=00`: funct 0001 → SLL 0111; otherwise ADD 0010.
  - `alu_op=01`: 0000 BEQ 0110; 0001 BNE 0101; 0100 BLT 1010; other → illegal 1111.
  - `alu_op=10`: 0000 ADD 0010; 1000 SUB 0110; 0111 AND 0000; 0110 OR 0001; 0100 XOR 0011; 0001 SLL 0111; 0101 SRL 1000; 1101 SRA 1001; 1100 MUL 1100 (macro only); other → 1111.
  - `alu_op=11`: 1111.
- Branch ops: BEQ/BNE `result = a - b`, `branch_taken` = (a==b)/(a!=b). BLT `result` = 1 if `$signed(a) < $signed(b)` else 0, `branch_taken` = same bit. Non-branch ops: `branch_taken=0`.
- Illegal: `result=0`, `zero=1`, `illegal=1`, `branch_taken=0`, single-cycle.
- Arithmetic modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE + `in_valid` + !`flush`: accept. Single-cycle op or shift with shamt ≤ 1 → compute, pulse `out_valid`, stay IDLE. Shift with shamt > 1 → first bit shifted at accept edge, counter = shamt-1, go to SHIFT.
  - SHIFT: one bit per edge (SRA replicates sign); at the edge where counter==1, write `result`, pulse `out_valid`, go to IDLE.
  - MUL: see Configuration.
- Operands and decoded op are latched at accept; `a`/`b` changes during SHIFT/MUL are ignored.
- `flush` in SHIFT/MUL: go to IDLE at next edge, no `out_valid`, outputs hold previous values. `flush` with `in_valid` in IDLE: nothing accepted.
- `stall` = (state ≠ IDLE) | (IDLE & `in_valid` & !`flush` & op is multi-cycle). `in_valid` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, `out_valid=0`, `result=0`, `zero=0`, `branch_taken=0`, `illegal=0`. `stall` and `operation` follow their combinational equations.
- Reset mid-operation discards the op immediately; no `out_valid` after release.
- Single-cycle op accepted at edge E0 → `out_valid` high in the cycle after E0.
- Shift latency max(1, shamt) edges. A shift with shamt k has `stall` high for k-1 cycles (accept cycle through the cycle before final edge only while in SHIFT; next op accepted at the first IDLE edge).
- Back-to-back single-cycle ops: one per cycle, `out_valid` continuous.
- `out_valid` is never high for two cycles from one op.

## Configuration
- `ALU_EXEC_MUL_EN`: defined → MUL (alu_op 10, funct 1100) is a shift-add multiplier, one multiplier bit per edge, WIDTH edges from accept to `out_valid`, low WIDTH bits of product. `stall` is high from the accept cycle through the cycle before the final edge. Undefined → funct 1100 decodes to 1111 (illegal), MUL state absent.

## Test plan
- Reset asserted mid-SHIFT (a=1, b=40, after 10 cycles) → all outputs 0 immediately, no `out_valid` after release.
- alu_op=10 funct=1000, a=5, b=5 → next cycle `result=0`, `zero=1`, `out_valid=1`; then funct=0111 a=0xF0 b=0x3C → `result=0x30` one cycle later (back-to-back).
- alu_op=01 funct=0100, a=-1, b=1 → `result=1`, `branch_taken=1`; funct=0001 a=b=7 → `branch_taken=0`.
- alu_op=10 funct=1101, a=0x8000_0000_0000_0000, b=4 → `stall` high 3 cycles, `out_valid` 4 edges after accept, `result=0xF800_0000_0000_0000`; shamt=0 → 1-cycle, `result=a`.
- SLL shamt=20 with `flush` pulsed on cycle 5 → no `out_valid`, IDLE next cycle, following ADD 2+3 → `result=5`.
- MUL 7×6: with `ALU_EXEC_MUL_EN` → `result=42` after 64 edges; without → `illegal=1`, `result=0` after 1 cycle.
